dbg_responder: RTL and testbench
================================

Name: dbg_responder

Overview:
- Hardware end of the bench-side debug protocol.
- A host initiator issues commands over a valid/ready channel: load memory words, read memory, read a register, or clear the register file.
- The block halts the CPU core, performs the memory/regfile access through dedicated side ports, and returns exactly one response per command.
- Sits beside `cpu`, muxed into the memory and register-file write/read paths while `cpu_halt` is high.

Parameters:
- ADDR_W, 16, word-address width of the memory side port (cmd_addr low bits used).
- MEM_RD_LAT, 1, memory read latency in cycles (1..4) from mem_addr valid to mem_rdata valid.
- NUM_REGS, 32, register-file depth; register 0 is never written.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  block accepts command.
- cmd_op  in  2  00 MEMWR, 01 MEMRD, 10 REGRD, 11 REGCLR.
- cmd_addr  in  32  word address (MEM*) or register index in bits [4:0] (REGRD).
- cmd_wdata  in  32  write data for MEMWR.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  32  response payload.
- cpu_halt  out  1  core stall/mux-select.
- pc_clear  out  1  one-cycle pulse forcing PC to 0.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  5  register write index.
- rf_wdata  out  32  register write data (always 0).
- rf_raddr  out  5  register read index.
- rf_rdata  in  32  combinational register read data.

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0 except cmd_ready=1; counters cleared. An in-flight REGCLR aborts; writes already done are not undone. No response is produced for an aborted command.
- States: IDLE, MEMWR, MEMRD, REGRD, CLR, RESP.
- IDLE:
  - cmd_ready=1, cpu_halt=0.
  - On cmd_valid at edge T: latch op/addr/wdata and go to the op state.
  - cpu_halt=1 from T+1 until the cycle after the response handshake.
- MEMWR (1 cycle, T+1):
  - mem_we=1, mem_addr=cmd_addr[ADDR_W-1:0], mem_wdata=cmd_wdata.
  - Next state RESP, rsp_data=0.
- MEMRD:
  - mem_addr is driven from T+1 for MEM_RD_LAT cycles.
  - mem_rdata is captured at the end of the last of those cycles.
  - Next state RESP, rsp_data=captured value.
- REGRD (1 cycle):
  - rf_raddr=cmd_addr[4:0]; capture rf_rdata.
  - Next state RESP. Index 0 returns whatever the regfile gives (0).
- CLR:
  - 5-bit counter runs 1..NUM_REGS-1, one write per cycle: rf_we=1, rf_waddr=count, rf_wdata=0.
  - Covers cycles T+1..T+31.
  - pc_clear=1 on the final write cycle only.
  - Next state RESP, rsp_data=NUM_REGS-1 (31).
- RESP:
  - rsp_valid=1; rsp_data held stable until rsp_ready.
  - On handshake go to IDLE.
  - cmd_ready=0 throughout; cmd_valid is ignored.
  - Back-to-back commands incur ≥1 IDLE cycle.
- cmd_ready is 0 in every non-IDLE state.
- mem_we and rf_we are never high simultaneously, and never high outside MEMWR/CLR.
- Upper cmd_addr bits are ignored (no error): beyond ADDR_W for memory, beyond [4:0] for registers.
- cpu_halt is registered; no glitch on accept.

Decomposition:
- Package dbg_pkg holds:
  - opcode constants OP_MEMWR/OP_MEMRD/OP_REGRD/OP_REGCLR;
  - state encoding;
  - REG_IDX_W=5.
- One sub-module, rf_clear_seq:
  - start/busy/done counter emitting rf_we/rf_waddr and a last-cycle flag used for pc_clear.

Test Plan:
1. MEMWR addr 0x1000, data 0xDEADBEEF → mem_we high exactly one cycle at T+1 with mem_addr 0x1000; rsp_data=0; cpu_halt high T+1 until handshake.
2. MEMRD addr 0x1000 after test 1, with MEM_RD_LAT=1 and 3 → rsp_data=0xDEADBEEF; rsp_valid at T+2 and T+4 respectively.
3. Load program via MEMWR words, release halt, run; then REGRD idx 2 → rsp_data=0x0000010E. REGRD idx 0 → 0.
4. REGCLR → exactly 31 rf_we cycles, rf_waddr 1..31 in order, data 0; pc_clear one pulse on the waddr=31 cycle; rsp_data=31. Subsequent REGRD of any register returns 0.
5. Hold rsp_ready=0 for 10 cycles with cmd_valid=1 → rsp_valid and rsp_data stable, cmd_ready=0, no second accept; accept occurs only after the handshake plus an IDLE cycle.
6. Assert rst_n=0 mid-REGCLR at waddr=10 → outputs 0 asynchronously, cmd_ready=1 after release, no response emitted; regs 1..9 or 10 remain cleared, others unchanged.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug responder: command opcodes, FSM state
// encoding and register-index width.
package dbg_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [1:0] OP_MEMWR  = 2'b00;
  localparam logic [1:0] OP_MEMRD  = 2'b01;
  localparam logic [1:0] OP_REGRD  = 2'b10;
  localparam logic [1:0] OP_REGCLR = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MEMWR = 3'd1;
  localparam logic [2:0] ST_MEMRD = 3'd2;
  localparam logic [2:0] ST_REGRD = 3'd3;
  localparam logic [2:0] ST_CLR   = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  // Map an accepted opcode to the state that services it.
  function automatic logic [2:0] op_to_state(input logic [1:0] op);
    logic [2:0] st;
    st = ST_IDLE;
    case (op)
      OP_MEMWR:  st = ST_MEMWR;
      OP_MEMRD:  st = ST_MEMRD;
      OP_REGRD:  st = ST_REGRD;
      OP_REGCLR: st = ST_CLR;
      default:   st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dbg_responder_rf_clear_seq.sv
// Register-file clear sequencer: after a start pulse, walks the write index
// from 1 up to NUM_REGS-1, one write per cycle. Register 0 is hardwired and
// is skipped. last_o marks the final write cycle (sequence done).
module rf_clear_seq
  import dbg_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 last_o,
  output logic [REG_IDX_W-1:0] waddr_o
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  logic                 busy_q, busy_d;
  logic [REG_IDX_W-1:0] cnt_q, cnt_d;

  // Start loads index 1; each busy cycle advances until the last register.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (cnt_q == LAST_IDX) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = REG_IDX_W'(1);
    end
  end

  // Counter and busy flag; reset aborts a sequence mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o  = busy_q;
  assign last_o  = busy_q && (cnt_q == LAST_IDX);
  assign waddr_o = busy_q ? cnt_q : '0;

endmodule

// File: rtl/dbg_responder.sv
// Debug responder: accepts host commands, halts the core, performs the
// memory / register-file access through side ports and returns exactly one
// response per command.
//
//   state | meaning
//   IDLE  | ready for a command, core running
//   MEMWR | one-cycle memory write strobe
//   MEMRD | hold mem_addr for MEM_RD_LAT cycles, capture mem_rdata at the end
//   REGRD | drive rf_raddr, capture rf_rdata
//   CLR   | zero registers 1..NUM_REGS-1, pc_clear on the last write
//   RESP  | present rsp_data until the host takes it
module dbg_responder
  import dbg_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MEM_RD_LAT = 1,
  parameter int NUM_REGS   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 cpu_halt,
  output logic                 pc_clear,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [REG_IDX_W-1:0] rf_raddr,
  input  logic [31:0]          rf_rdata
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_RD_LAT - 1);

  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          data_q, data_d;
  logic [1:0]           lat_q, lat_d;
  logic                 halt_q, halt_d;

  logic                 clr_start;
  logic                 clr_busy;
  logic                 clr_last;
  logic [REG_IDX_W-1:0] clr_waddr;

  // Address bits above the memory window are don't-care by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_addr[31:ADDR_W];

  rf_clear_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (clr_start),
    .busy_o  (clr_busy),
    .last_o  (clr_last),
    .waddr_o (clr_waddr)
  );

  // Next-state, command latching and response capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    lat_d     = lat_q;
    clr_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = op_to_state(cmd_op);
          addr_d    = cmd_addr[ADDR_W-1:0];
          idx_d     = cmd_addr[REG_IDX_W-1:0];
          wdata_d   = cmd_wdata;
          lat_d     = LAT_INIT;
          clr_start = (cmd_op == OP_REGCLR);
        end
      end
      ST_MEMWR: begin
        data_d  = '0;
        state_d = ST_RESP;
      end
      ST_MEMRD: begin
        if (lat_q == 2'd0) begin
          data_d  = mem_rdata;
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_REGRD: begin
        data_d  = rf_rdata;
        state_d = ST_RESP;
      end
      ST_CLR: begin
        if (clr_last) begin
          data_d  = 32'(NUM_REGS - 1);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Halt follows the next state so it rises on the first busy cycle and
  // drops on the first idle cycle, glitch-free from a flop.
  assign halt_d = (state_d != ST_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      lat_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      lat_q   <= lat_d;
      halt_q  <= halt_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = (state_q == ST_RESP) ? data_q : '0;
  assign cpu_halt  = halt_q;

  assign mem_we    = (state_q == ST_MEMWR);
  assign mem_addr  = ((state_q == ST_MEMWR) || (state_q == ST_MEMRD)) ? addr_q : '0;
  assign mem_wdata = (state_q == ST_MEMWR) ? wdata_q : '0;

  assign rf_we     = (state_q == ST_CLR) && clr_busy;
  assign rf_waddr  = (state_q == ST_CLR) ? clr_waddr : '0;
  assign rf_wdata  = '0;
  assign rf_raddr  = (state_q == ST_REGRD) ? idx_q : '0;
  assign pc_clear  = (state_q == ST_CLR) && clr_last;

endmodule

// File: tb/tb_dbg_responder.sv
// Bench for dbg_responder: behavioural memory/regfile around the DUT, a
// command-level reference model feeding a scoreboard queue, and a monitor
// that checks responses, latency, strobes and halt/ready.
module tb_dbg_responder;
  import dbg_pkg::*;

  localparam int ADDR_W = 16;
  localparam int LAT    = 3;
  localparam int NR     = 32;
  localparam int P      = 10;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        cpu_halt, pc_clear, mem_we, rf_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rf_wdata, rf_rdata;
  logic [4:0]  rf_waddr, rf_raddr;

  dbg_responder #(.ADDR_W(ADDR_W), .MEM_RD_LAT(LAT), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cpu_halt(cpu_halt), .pc_clear(pc_clear),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  initial clk = 1'b0;
  always #(P/2) clk = ~clk;

  // Physical memory / regfile seen by the DUT, plus a core write port
  // that only works while the core is not halted.
  bit [31:0] phys_mem [0:65535];
  bit [31:0] phys_rf  [0:31];
  logic      cpu_we;
  logic [4:0] cpu_idx;
  logic [31:0] cpu_val;

  assign mem_rdata = phys_mem[mem_addr];
  assign rf_rdata  = phys_rf[rf_raddr];

  always @(posedge clk) begin
    if (mem_we) phys_mem[mem_addr] <= mem_wdata;
    if (rf_we && rf_waddr != 5'd0) phys_rf[rf_waddr] <= rf_wdata;
    else if (cpu_we && !cpu_halt && cpu_idx != 5'd0) phys_rf[cpu_idx] <= cpu_val;
  end

  // Reference model state.
  bit [31:0] ref_mem [0:65535];
  bit [31:0] ref_rf  [0:31];

  typedef struct {
    logic [31:0] data;
    int          k;
    time         t_acc;
    logic [1:0]  op;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] cur_addr, cur_wdata;
  int  we_cnt, rf_cnt, pc_cnt, clr_next;
  bit  in_rsp;
  logic [31:0] held;
  bit  hold_valid, hold_rsp;
  logic tb_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level semantics: what each command does and returns, and how
  // many cycles after acceptance its response appears.
  task automatic model_apply(input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, output exp_t e);
    e.op = op;
    case (op)
      OP_MEMWR: begin ref_mem[addr[ADDR_W-1:0]] = wd; e.data = 0; e.k = 2; end
      OP_MEMRD: begin e.data = ref_mem[addr[ADDR_W-1:0]]; e.k = 1 + LAT; end
      OP_REGRD: begin e.data = ref_rf[addr[4:0]]; e.k = 2; end
      default: begin
        for (int i = 1; i < NR; i++) ref_rf[i] = 0;
        e.data = NR - 1;
        e.k = NR;
      end
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input bit track);
    bit ready_s, done;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      ready_s = cmd_ready;
      @(posedge clk);
      if (ready_s) begin
        done = 1;
        cur_addr = addr; cur_wdata = wd;
        we_cnt = 0; rf_cnt = 0; pc_cnt = 0; clr_next = 1;
        if (track) begin
          model_apply(op, addr, wd, e);
          e.t_acc = $time;
          q.push_back(e);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout: op %0d never accepted", op);
    end
    if (!hold_valid) begin #1; cmd_valid = 1'b0; end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && tb_busy === 1'b0) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d responses outstanding", q.size());
    end
  endtask

  task automatic cpu_write(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    cpu_we = 1'b1; cpu_idx = idx; cpu_val = val;
    @(negedge clk);
    cpu_we = 1'b0;
    if (idx != 0) ref_rf[idx] = val;
  endtask

  task automatic check_reset_outs();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_ctrl", {27'd0, rsp_valid, cpu_halt, pc_clear, mem_we, rf_we}, 32'd0);
    chk("rst_buses", 32'(mem_addr) | mem_wdata | rsp_data | 32'(rf_waddr) | 32'(rf_raddr), 32'd0);
  endtask

  // Expected busy window: from the cycle after accept to the handshake cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_busy <= 1'b0;
    else if (cmd_valid && cmd_ready) tb_busy <= 1'b1;
    else if (rsp_valid && rsp_ready) tb_busy <= 1'b0;
  end

  // Host response-ready: random backpressure, or held low on request.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   k_meas;
    if (rst_n) begin
      chk("halt", 32'(cpu_halt), 32'(tb_busy));
      chk("cmd_ready", 32'(cmd_ready), 32'(!tb_busy));
      if (mem_we || rf_we) chk("we_excl", 32'(mem_we & rf_we), 32'd0);
      if (mem_we) begin
        we_cnt++;
        chk("mem_addr", 32'(mem_addr), 32'(cur_addr[ADDR_W-1:0]));
        chk("mem_wdata", mem_wdata, cur_wdata);
      end
      if (rf_we) begin
        rf_cnt++;
        chk("rf_waddr", 32'(rf_waddr), 32'(clr_next));
        chk("rf_wdata", rf_wdata, 32'd0);
        chk("pc_clear", 32'(pc_clear), 32'(clr_next == NR - 1));
        clr_next++;
      end
      if (pc_clear) pc_cnt++;
      if (rsp_valid) begin
        if (!in_rsp) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: data %h with nothing outstanding", rsp_data);
          end else begin
            e = q[0];
            k_meas = int'(($time - e.t_acc - P/2) / P) + 1;
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_latency", 32'(k_meas), 32'(e.k));
            case (e.op)
              OP_MEMWR: begin
                chk("memwr_we_cycles", 32'(we_cnt), 32'd1);
                chk("memwr_rf_cycles", 32'(rf_cnt), 32'd0);
              end
              OP_REGCLR: begin
                chk("clr_rf_cycles", 32'(rf_cnt), 32'(NR - 1));
                chk("clr_pc_pulses", 32'(pc_cnt), 32'd1);
                chk("clr_we_cycles", 32'(we_cnt), 32'd0);
              end
              default: chk("rd_strobes", 32'(we_cnt + rf_cnt + pc_cnt), 32'd0);
            endcase
          end
          in_rsp = 1;
          held = rsp_data;
        end else begin
          chk("rsp_stable", rsp_data, held);
        end
        if (rsp_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          in_rsp = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    bit ok;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 0; cmd_wdata = 0;
    cpu_we = 1'b0; cpu_idx = 0; cpu_val = 0;
    hold_valid = 0; hold_rsp = 0; in_rsp = 0; held = 0;
    cur_addr = 0; cur_wdata = 0; we_cnt = 0; rf_cnt = 0; pc_cnt = 0; clr_next = 1;
    #3;
    check_reset_outs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read-back, upper address bits ignored.
    send(OP_MEMWR, 32'h0000_1000, 32'hDEAD_BEEF, 1);
    drain();
    send(OP_MEMRD, 32'h0000_1000, 32'h0, 1);
    send(OP_MEMRD, 32'hABCD_1000, 32'h0, 1);
    drain();

    // Program load, core runs and writes r2, then register reads.
    for (int i = 0; i < 4; i++) send(OP_MEMWR, 32'(i), $urandom, 1);
    drain();
    cpu_write(5'd2, 32'h0000_010E);
    cpu_write(5'd7, 32'h1234_5678);
    send(OP_REGRD, 32'd2, 32'h0, 1);
    send(OP_REGRD, 32'd0, 32'h0, 1);
    send(OP_REGRD, 32'hFFFF_FFE2, 32'h0, 1);
    send(OP_REGRD, 32'd7, 32'h0, 1);
    drain();

    // Full register clear, then reads.
    send(OP_REGCLR, 32'h0, 32'h0, 1);
    send(OP_REGRD, 32'd2, 32'h0, 1);
    send(OP_REGRD, 32'd31, 32'h0, 1);
    drain();

    // Response backpressure with the host still pushing a command.
    hold_rsp = 1; hold_valid = 1;
    send(OP_MEMRD, 32'h0000_1000, 32'h0, 1);
    repeat (12) @(negedge clk);
    hold_rsp = 0;
    send(OP_REGRD, 32'd5, 32'h0, 1);
    hold_valid = 0;
    #1 cmd_valid = 1'b0;
    drain();

    // Randomized command mix.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      if (op == OP_REGCLR && $urandom_range(0, 3) != 0) op = OP_REGRD;
      a = {16'($urandom), 16'h1000 + 16'($urandom_range(0, 15))};
      if (op == OP_REGRD) a = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        drain();
        cpu_write(5'($urandom_range(0, 31)), $urandom);
      end
      send(op, a, $urandom, 1);
    end
    drain();

    // Reset in the middle of a clear: no response, partial clear stays.
    for (int i = 1; i < NR; i++) cpu_write(5'(i), $urandom | 32'h1);
    send(OP_REGCLR, 32'h0, 32'h0, 0);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (rf_we && rf_waddr == 5'd10) ok = 1;
    end
    chk("clr_reach_10", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    q.delete();
    in_rsp = 0;
    for (int i = 1; i < 10; i++) ref_rf[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    send(OP_REGRD, 32'd1, 32'h0, 1);
    send(OP_REGRD, 32'd9, 32'h0, 1);
    send(OP_REGRD, 32'd10, 32'h0, 1);
    send(OP_REGRD, 32'd20, 32'h0, 1);
    send(OP_REGRD, 32'd31, 32'h0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
